// File: rtl/butterfly_entry_ctrl.sv
// Front-panel sequencer for the FFT butterfly: operand entry, start/wait with
// timeout, and stepping the four results onto the display bus.
module butterfly_entry_ctrl #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic [W-1:0] data_sw,
  input  logic         next_pulse,
  input  logic         clear_pulse,
  output logic [W-1:0] a_re,
  output logic [W-1:0] a_im,
  output logic [W-1:0] b_re,
  output logic [W-1:0] b_im,
  output logic [W-1:0] w_re,
  output logic [W-1:0] w_im,
  output logic         bf_start,
  input  logic         bf_done,
  input  logic [W-1:0] y0_re,
  input  logic [W-1:0] y0_im,
  input  logic [W-1:0] y1_re,
  input  logic [W-1:0] y1_im,
  output logic [W-1:0] disp_value,
  output logic [3:0]   state_idx,
  output logic         busy,
  output logic         err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    LD_ARE    = 4'd0,
    LD_AIM    = 4'd1,
    LD_BRE    = 4'd2,
    LD_BIM    = 4'd3,
    LD_WRE    = 4'd4,
    LD_WIM    = 4'd5,
    START     = 4'd6,
    WAIT_DONE = 4'd7,
    SHOW_Y0RE = 4'd8,
    SHOW_Y0IM = 4'd9,
    SHOW_Y1RE = 4'd10,
    SHOW_Y1IM = 4'd11,
    ERR       = 4'd15
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_a_re, r_a_im, r_b_re, r_b_im, r_w_re, r_w_im;
  logic [W-1:0]    r_y0_re, r_y0_im, r_y1_re, r_y1_im;

  // State register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) r_state <= LD_ARE;
    else         r_state <= w_next;
  end

  // Next-state logic; clear overrides everything, unused codes recover to LD_ARE
  always_comb begin
    w_next = r_state;
    if (clear_pulse) begin
      w_next = LD_ARE;
    end else begin
      case (r_state)
        LD_ARE:    w_next = next_pulse ? LD_AIM    : LD_ARE;
        LD_AIM:    w_next = next_pulse ? LD_BRE    : LD_AIM;
        LD_BRE:    w_next = next_pulse ? LD_BIM    : LD_BRE;
        LD_BIM:    w_next = next_pulse ? LD_WRE    : LD_BIM;
        LD_WRE:    w_next = next_pulse ? LD_WIM    : LD_WRE;
        LD_WIM:    w_next = next_pulse ? START     : LD_WIM;
        START:     w_next = WAIT_DONE;
        WAIT_DONE: begin
          if (bf_done)                w_next = SHOW_Y0RE;
          else if (r_cnt == {CW{1'b0}}) w_next = ERR;
          else                        w_next = WAIT_DONE;
        end
        SHOW_Y0RE: w_next = next_pulse ? SHOW_Y0IM : SHOW_Y0RE;
        SHOW_Y0IM: w_next = next_pulse ? SHOW_Y1RE : SHOW_Y0IM;
        SHOW_Y1RE: w_next = next_pulse ? SHOW_Y1IM : SHOW_Y1RE;
        SHOW_Y1IM: w_next = next_pulse ? LD_ARE    : SHOW_Y1IM;
        ERR:       w_next = next_pulse ? LD_ARE    : ERR;
        default:   w_next = LD_ARE;
      endcase
    end
  end

  // Operand capture, result latch and timeout counter
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset || clear_pulse) begin
      r_a_re  <= {W{1'b0}};
      r_a_im  <= {W{1'b0}};
      r_b_re  <= {W{1'b0}};
      r_b_im  <= {W{1'b0}};
      r_w_re  <= {W{1'b0}};
      r_w_im  <= {W{1'b0}};
      r_y0_re <= {W{1'b0}};
      r_y0_im <= {W{1'b0}};
      r_y1_re <= {W{1'b0}};
      r_y1_im <= {W{1'b0}};
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        LD_ARE: if (next_pulse) r_a_re <= data_sw;
        LD_AIM: if (next_pulse) r_a_im <= data_sw;
        LD_BRE: if (next_pulse) r_b_re <= data_sw;
        LD_BIM: if (next_pulse) r_b_im <= data_sw;
        LD_WRE: if (next_pulse) r_w_re <= data_sw;
        LD_WIM: if (next_pulse) r_w_im <= data_sw;
        START:  r_cnt <= CW'(TIMEOUT - 1);
        WAIT_DONE: begin
          if (bf_done) begin
            r_y0_re <= y0_re;
            r_y0_im <= y0_im;
            r_y1_re <= y1_re;
            r_y1_im <= y1_im;
          end
          // Saturating countdown: expiry is detected at zero, never wraps
          if (r_cnt != {CW{1'b0}}) r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Display mux: live switch preview while loading, latched results while showing
  always_comb begin
    disp_value = {W{1'b0}};
    case (r_state)
      LD_ARE, LD_AIM, LD_BRE, LD_BIM, LD_WRE, LD_WIM: disp_value = data_sw;
      SHOW_Y0RE: disp_value = r_y0_re;
      SHOW_Y0IM: disp_value = r_y0_im;
      SHOW_Y1RE: disp_value = r_y1_re;
      SHOW_Y1IM: disp_value = r_y1_im;
      default:   disp_value = {W{1'b0}};
    endcase
  end

  assign a_re      = r_a_re;
  assign a_im      = r_a_im;
  assign b_re      = r_b_re;
  assign b_im      = r_b_im;
  assign w_re      = r_w_re;
  assign w_im      = r_w_im;
  assign state_idx = r_state;
  assign bf_start  = (r_state == START);
  assign busy      = (r_state == START) || (r_state == WAIT_DONE);
  assign err       = (r_state == ERR);

endmodule

// File: tb/tb_butterfly_entry_ctrl.sv
// Directed bench for butterfly_entry_ctrl with operand/result scoreboards.
module tb_butterfly_entry_ctrl;
  localparam int W  = 16;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         nReset;
  logic [W-1:0] data_sw;
  logic         next_pulse, clear_pulse, bf_done;
  logic [W-1:0] y0_re, y0_im, y1_re, y1_im;
  logic [W-1:0] a_re, a_im, b_re, b_im, w_re, w_im, disp_value;
  logic         bf_start, busy, err;
  logic [3:0]   state_idx;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] op_q[$];
  logic [W-1:0] res_q[$];

  butterfly_entry_ctrl #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .nReset(nReset), .data_sw(data_sw), .next_pulse(next_pulse),
    .clear_pulse(clear_pulse), .a_re(a_re), .a_im(a_im), .b_re(b_re),
    .b_im(b_im), .w_re(w_re), .w_im(w_im), .bf_start(bf_start),
    .bf_done(bf_done), .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re),
    .y1_im(y1_im), .disp_value(disp_value), .state_idx(state_idx),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_next(input logic [W-1:0] v);
    data_sw = v;
    next_pulse = 1'b1;
    step();
    next_pulse = 1'b0;
  endtask

  // Load six operands base..base+5, recording them for the START check
  task automatic load6(input logic [W-1:0] base);
    for (int i = 0; i < 6; i++) begin
      op_q.push_back(base + W'(i));
      pulse_next(base + W'(i));
    end
  endtask

  task automatic check_start();
    chk("start_state", {12'd0, state_idx}, 16'd6);
    chk("start_bf", {15'd0, bf_start}, 16'd1);
    chk("start_busy", {15'd0, busy}, 16'd1);
    chk("start_disp", disp_value, 16'd0);
    chk("op_a_re", a_re, op_q.pop_front());
    chk("op_a_im", a_im, op_q.pop_front());
    chk("op_b_re", b_re, op_q.pop_front());
    chk("op_b_im", b_im, op_q.pop_front());
    chk("op_w_re", w_re, op_q.pop_front());
    chk("op_w_im", w_im, op_q.pop_front());
  endtask

  task automatic done_with(input logic [W-1:0] base);
    y0_re = base; y0_im = base + 16'h10; y1_re = base + 16'h20; y1_im = base + 16'h30;
    res_q.push_back(y0_re); res_q.push_back(y0_im);
    res_q.push_back(y1_re); res_q.push_back(y1_im);
    bf_done = 1'b1;
    step();
    bf_done = 1'b0;
  endtask

  task automatic show_all();
    for (int i = 0; i < 4; i++) begin
      chk("show_state", {12'd0, state_idx}, 16'd8 + 16'(i));
      chk("show_disp", disp_value, res_q.pop_front());
      pulse_next(16'hBEEF);
    end
    chk("show_end_state", {12'd0, state_idx}, 16'd0);
  endtask

  initial begin
    int n;
    nReset = 1'b0; data_sw = 16'h1234; next_pulse = 1'b0; clear_pulse = 1'b0;
    bf_done = 1'b0; y0_re = '0; y0_im = '0; y1_re = '0; y1_im = '0;
    #3;
    chk("rst_state", {12'd0, state_idx}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_bf", {15'd0, bf_start}, 16'd0);
    chk("rst_a_re", a_re, 16'd0);
    chk("rst_preview", disp_value, 16'h1234);
    #4 nReset = 1'b1;
    step();

    // Normal run
    load6(16'd1);
    check_start();
    step();
    chk("wait_state", {12'd0, state_idx}, 16'd7);
    chk("wait_bf", {15'd0, bf_start}, 16'd0);
    chk("wait_busy", {15'd0, busy}, 16'd1);
    pulse_next(16'h7777);
    chk("wait_ignore_next", {12'd0, state_idx}, 16'd7);
    done_with(16'h0010);
    show_all();
    chk("keep_a_re", a_re, 16'd1);
    chk("keep_w_im", w_im, 16'd6);

    // Timeout: WAIT_DONE lasts exactly TO cycles after the bf_start cycle
    load6(16'h0100);
    check_start();
    step();
    n = 0;
    while (state_idx == 4'd7 && n < 20) begin
      n++;
      step();
    end
    chk("wait_cycles", 16'(n), 16'(TO));
    chk("err_state", {12'd0, state_idx}, 16'd15);
    chk("err_flag", {15'd0, err}, 16'd1);
    chk("err_disp", disp_value, 16'd0);
    pulse_next(16'd0);
    chk("err_exit", {12'd0, state_idx}, 16'd0);
    chk("err_keep_ops", a_re, 16'h0100);

    // bf_done in the expiry cycle wins
    load6(16'h0200);
    check_start();
    for (int i = 0; i < TO; i++) step();
    done_with(16'h0A00);
    show_all();

    // Clear at LD_BIM
    pulse_next(16'd1); pulse_next(16'd2); pulse_next(16'd3);
    chk("ld_bim_state", {12'd0, state_idx}, 16'd3);
    clear_pulse = 1'b1; step(); clear_pulse = 1'b0;
    chk("clr_state", {12'd0, state_idx}, 16'd0);
    chk("clr_a_re", a_re, 16'd0);
    chk("clr_a_im", a_im, 16'd0);
    chk("clr_b_re", b_re, 16'd0);

    // Clear during WAIT_DONE, late bf_done ignored
    load6(16'h0300);
    check_start();
    step();
    clear_pulse = 1'b1; step(); clear_pulse = 1'b0;
    chk("clr_wait_state", {12'd0, state_idx}, 16'd0);
    chk("clr_wait_busy", {15'd0, busy}, 16'd0);
    y0_re = 16'hDEAD; bf_done = 1'b1; step(); bf_done = 1'b0;
    chk("late_done_state", {12'd0, state_idx}, 16'd0);
    chk("late_done_bf", {15'd0, bf_start}, 16'd0);

    // next and clear together at LD_AIM
    pulse_next(16'h0055);
    chk("ld_aim_state", {12'd0, state_idx}, 16'd1);
    data_sw = 16'h0066; next_pulse = 1'b1; clear_pulse = 1'b1;
    step();
    next_pulse = 1'b0; clear_pulse = 1'b0;
    chk("both_state", {12'd0, state_idx}, 16'd0);
    chk("both_a_im", a_im, 16'd0);
    chk("both_a_re", a_re, 16'd0);

    // Async reset mid-WAIT_DONE
    load6(16'h0400);
    check_start();
    step();
    #2 nReset = 1'b0;
    #1;
    chk("arst_state", {12'd0, state_idx}, 16'd0);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_bf", {15'd0, bf_start}, 16'd0);
    chk("arst_a_re", a_re, 16'd0);
    chk("arst_w_im", w_im, 16'd0);
    #2 nReset = 1'b1;
    step();
    chk("post_rst_state", {12'd0, state_idx}, 16'd0);
    chk("post_rst_bf", {15'd0, bf_start}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/butterfly_entry_ctrl.md
Name: butterfly_entry_ctrl

Overview:
Front-panel sequencer for the FFT butterfly datapath on the board. It takes one-cycle pulses from the switch debouncers and the value on the data switches. With these it loads the six butterfly operands one at a time, starts the butterfly, and waits for completion with a timeout. It then steps the four results onto a display bus. It sits between the debounced user inputs and the butterfly core/display driver.

Parameters:
W, 16, width of every operand, result and data-switch word
TIMEOUT, 1024, max cycles in WAIT_DONE before ERR (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
nReset  input  1  asynchronous active-low reset
data_sw  input  W  raw operand value from the switches (quasi-static)
next_pulse  input  1  one-cycle debounced pulse: capture / advance
clear_pulse  input  1  one-cycle debounced pulse: abort to start
a_re, a_im, b_re, b_im, w_re, w_im  output  W each  registered operands to the butterfly
bf_start  output  1  one-cycle start strobe to the butterfly
bf_done  input  1  butterfly completion strobe; results valid in that cycle
y0_re, y0_im, y1_re, y1_im  input  W each  butterfly results
disp_value  output  W  value for the display driver
state_idx  output  4  current state code for the LEDs
busy  output  1  high in START and WAIT_DONE
err  output  1  high in ERR

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on nReset.
- Reset: state = LD_ARE; all operand and internal result registers = 0; timeout counter = 0; bf_start = 0, busy = 0, err = 0.
- States and state_idx codes:
  - LD_ARE 0, LD_AIM 1, LD_BRE 2, LD_BIM 3, LD_WRE 4, LD_WIM 5
  - START 6, WAIT_DONE 7
  - SHOW_Y0RE 8, SHOW_Y0IM 9, SHOW_Y1RE 10, SHOW_Y1IM 11
  - ERR 15; codes 12-14 unused, and any unused code goes to LD_ARE on the next cycle.
- LD_x: on next_pulse, the operand register for x takes data_sw at the clock edge. The state advances in order LD_ARE..LD_WIM, then to START. Without a pulse the state and registers hold. disp_value = data_sw, combinational live preview.
- START: lasts exactly one cycle. bf_start = 1 and busy = 1. Counter loads TIMEOUT-1. Next state is WAIT_DONE. bf_start is high for one cycle per run, never more.
- WAIT_DONE: busy = 1 and the counter decrements each cycle.
  - bf_done = 1: y0_re..y1_im latch into the internal result registers; next state SHOW_Y0RE.
  - bf_done = 0 and counter = 0: next state ERR.
  - bf_done and counter expiry in the same cycle: bf_done wins.
  - next_pulse is ignored here and in START.
- SHOW_x: disp_value = latched result x. next_pulse advances SHOW_Y0RE -> Y0IM -> Y1RE -> Y1IM -> LD_ARE. Operands are retained, so a new entry overwrites them one at a time.
- ERR: err = 1. next_pulse goes to LD_ARE. Operands are retained and result registers are unchanged.
- disp_value = 0 in START, WAIT_DONE and ERR.
- clear_pulse has highest priority in every state. Next state is LD_ARE and all operand and result registers are zeroed in that cycle. No bf_start is issued. A clear during WAIT_DONE abandons the run, and a late bf_done seen in LD states is ignored.
- next_pulse and clear_pulse in the same cycle: clear wins.
- bf_done outside WAIT_DONE is ignored.
- All outputs except disp_value are registered or decoded from the state register. No output toggles combinationally from next_pulse.
- Counter width = clog2(TIMEOUT). Decrements have no wrap; the counter stops at 0 and ERR is taken.
- Reset asserted mid-run returns to reset values immediately, with no bf_start glitch.

Test Plan:
- Reset, then 6 next_pulses with data_sw = 0x0001..0x0006 -> a_re=1, a_im=2, b_re=3, b_im=4, w_re=5, w_im=6. One cycle later bf_start is high for exactly 1 cycle, then state_idx=7, busy=1.
- In WAIT_DONE, pulse bf_done with y0_re=0x0010, y0_im=0x0020, y1_re=0x0030, y1_im=0x0040 -> state_idx=8, disp_value=0x0010. Three next_pulses give 0x20, 0x30, 0x40; a fourth gives state_idx=0 with operands unchanged.
- No bf_done after START -> ERR (state_idx=15, err=1) exactly TIMEOUT cycles after the bf_start cycle. With TIMEOUT=8, bf_done arriving in the expiry cycle -> SHOW_Y0RE, not ERR.
- clear_pulse at LD_BIM (operands 1..3 loaded) -> state_idx=0, all operands=0. clear_pulse during WAIT_DONE -> LD_ARE, and a following bf_done leaves results at 0.
- next_pulse and clear_pulse in the same cycle at LD_AIM -> LD_ARE and a_im not loaded. next_pulse during WAIT_DONE -> no state change.
- Assert nReset mid-WAIT_DONE -> all outputs at reset values asynchronously. After release, state_idx=0 and bf_start=0.
